// File: rtl/data_offload_sync_gate.sv
// ============================================================================
// Module   : data_offload_sync_gate
// Purpose  : Holds stored read data until armed and triggered, then releases
//            frames of a programmed length to the DAC-facing AXI-Stream port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_offload_sync_gate #(
    parameter int DATA_WIDTH   = 128,
    parameter int LENGTH_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              cfg_sync_mode,
    input  logic                    cfg_oneshot,
    input  logic [LENGTH_WIDTH-1:0] cfg_length,
    input  logic                    arm,
    input  logic                    sync_ext,
    input  logic                    sw_sync,
    input  logic                    s_axis_valid,
    output logic                    s_axis_ready,
    input  logic [DATA_WIDTH-1:0]   s_axis_data,
    output logic                    m_axis_valid,
    input  logic                    m_axis_ready,
    output logic [DATA_WIDTH-1:0]   m_axis_data,
    output logic                    m_axis_last,
    output logic [1:0]              status_state,
    output logic                    frame_done,
    output logic [7:0]              sync_ignored_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync_prev_q;
    logic [LENGTH_WIDTH-1:0] cnt_q, cnt_d;
    logic [LENGTH_WIDTH-1:0] len_q, len_d;
    logic                    frame_done_q, frame_done_d;
    logic [7:0]              ign_q, ign_d;

    logic trig;
    logic in_run;
    logic beat;
    logic last_beat;

    always_comb begin
        case (cfg_sync_mode)
            2'd0:    trig = 1'b1;
            2'd2:    trig = sw_sync;
            default: trig = sync_ext & ~sync_prev_q;
        endcase
    end

    // Zero-latency pass-through; gated off entirely outside RUN.
    assign in_run       = (state_q == ST_RUN);
    assign m_axis_valid = in_run & s_axis_valid;
    assign s_axis_ready = in_run & m_axis_ready;
    assign m_axis_data  = s_axis_data;
    assign m_axis_last  = in_run & (cnt_q == len_q);
    assign beat         = m_axis_valid & m_axis_ready;
    assign last_beat    = beat & m_axis_last;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        frame_done_d = 1'b0;
        ign_d        = ign_q;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_ARMED;
                    len_d   = cfg_length;
                end
            end
            ST_ARMED: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end else if (trig) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (trig && (ign_q != 8'hFF)) begin
                    ign_d = ign_q + 8'd1;
                end
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Frame boundary: the frame is always finished before arm is honoured.
                if (last_beat) begin
                    frame_done_d = 1'b1;
                    cnt_d        = '0;
                    len_d        = cfg_length;
                    if (!arm || cfg_oneshot) begin
                        state_d = ST_IDLE;
                    end else if (cfg_sync_mode != 2'd0) begin
                        state_d = ST_ARMED;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sync_prev_q  <= 1'b0;
            cnt_q        <= '0;
            len_q        <= '0;
            frame_done_q <= 1'b0;
            ign_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            sync_prev_q  <= sync_ext;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            frame_done_q <= frame_done_d;
            ign_q        <= ign_d;
        end
    end

    assign status_state     = state_q;
    assign frame_done       = frame_done_q;
    assign sync_ignored_cnt = ign_q;

endmodule

`default_nettype wire

// File: tb/tb_data_offload_sync_gate.sv
// ============================================================================
// Module   : tb_data_offload_sync_gate
// Purpose  : Scoreboard bench for data_offload_sync_gate with directed stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_offload_sync_gate;

    localparam int DW = 128;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    cfg_sync_mode;
    logic          cfg_oneshot;
    logic [LW-1:0] cfg_length;
    logic          arm;
    logic          sync_ext;
    logic          sw_sync;
    logic          s_axis_valid;
    logic          s_axis_ready;
    logic [DW-1:0] s_axis_data;
    logic          m_axis_valid;
    logic          m_axis_ready;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_last;
    logic [1:0]    status_state;
    logic          frame_done;
    logic [7:0]    sync_ignored_cnt;

    data_offload_sync_gate #(.DATA_WIDTH(DW), .LENGTH_WIDTH(LW)) dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_sync_mode    (cfg_sync_mode),
        .cfg_oneshot      (cfg_oneshot),
        .cfg_length       (cfg_length),
        .arm              (arm),
        .sync_ext         (sync_ext),
        .sw_sync          (sw_sync),
        .s_axis_valid     (s_axis_valid),
        .s_axis_ready     (s_axis_ready),
        .s_axis_data      (s_axis_data),
        .m_axis_valid     (m_axis_valid),
        .m_axis_ready     (m_axis_ready),
        .m_axis_data      (m_axis_data),
        .m_axis_last      (m_axis_last),
        .status_state     (status_state),
        .frame_done       (frame_done),
        .sync_ignored_cnt (sync_ignored_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         e;
    logic [DW-1:0] src = '0;
    logic [DW-1:0] next_exp = '0;
    int            n_chk = 0;
    int            n_pass = 0;
    int            n_pop = 0;
    int            fd_count = 0;
    bit            fd_pending = 0;

    // Storage model: an incrementing word that advances on each accepted read.
    assign s_axis_data = src;
    always @(posedge clk) if (s_axis_valid && s_axis_ready) src <= src + 1'b1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int nbeats, input bit with_last);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.data = next_exp;
            b.last = with_last && (i == nbeats - 1);
            exp_q.push_back(b);
            next_exp = next_exp + 1'b1;
        end
    endtask

    task automatic wait_pops(input int target);
        int g = 0;
        while (n_pop < target && g < 2000) begin
            tick(1);
            g++;
        end
        chk("wait_pops_in_time", DW'(n_pop >= target), DW'(1));
    endtask

    task automatic pulse_sync();
        sync_ext = 1'b1;
        tick(1);
        sync_ext = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every handshake, tracks frame_done.
    always @(negedge clk) begin
        if (fd_pending) begin
            chk("frame_done_pulse", DW'(frame_done), DW'(1));
            if (frame_done) fd_count++;
            fd_pending = 0;
        end else if (frame_done) begin
            chk("frame_done_unexpected", DW'(frame_done), DW'(0));
        end
        if (m_axis_valid && m_axis_ready) begin
            chk("pass_through_ready", DW'(s_axis_ready), DW'(1));
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", m_axis_data, '1);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", m_axis_data, e.data);
                chk("beat_last", DW'(m_axis_last), DW'(e.last));
                if (e.last) fd_pending = 1;
            end
            n_pop++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fd0, p0, rem;
        reset = 1'b1; cfg_sync_mode = 2'd1; cfg_oneshot = 1'b1; cfg_length = '0;
        arm = 1'b0; sync_ext = 1'b0; sw_sync = 1'b0; s_axis_valid = 1'b1; m_axis_ready = 1'b1;
        tick(3);
        chk("rst_state", DW'(status_state), DW'(0));
        chk("rst_m_valid", DW'(m_axis_valid), DW'(0));
        chk("rst_s_ready", DW'(s_axis_ready), DW'(0));
        chk("rst_last", DW'(m_axis_last), DW'(0));
        chk("rst_ignored", DW'(sync_ignored_cnt), DW'(0));
        reset = 1'b0;

        // Hardware oneshot, 8 beats, 2-cycle sync pulse
        cfg_length = 16'd7; arm = 1'b1;
        tick(2);
        chk("t1_armed", DW'(status_state), DW'(1));
        push_frame(8, 1);
        sync_ext = 1'b1;
        tick(1);
        chk("t1_run", DW'(status_state), DW'(2));
        chk("t1_first_valid", DW'(m_axis_valid), DW'(1));
        tick(1);
        sync_ext = 1'b0;
        wait_pops(8);
        chk("t1_idle_after", DW'(status_state), DW'(0));
        arm = 1'b0;
        tick(2);
        chk("t1_frames", DW'(fd_count), DW'(1));

        // Repeated sync pulses, hardware cyclic, one mid-frame extra pulse
        cfg_oneshot = 1'b0; cfg_length = 16'd3; arm = 1'b1;
        tick(2);
        fd0 = fd_count;
        for (int k = 0; k < 4; k++) begin
            push_frame(4, 1);
            pulse_sync();
            if (k == 0) begin
                tick(1);
                pulse_sync();
            end
            tick(97);
            chk("t2_rearmed", DW'(status_state), DW'(1));
        end
        chk("t2_frames", DW'(fd_count - fd0), DW'(4));
        chk("t2_ignored", DW'(sync_ignored_cnt), DW'(1));

        // Arm drop mid-frame, then arm drop while ARMED
        arm = 1'b0;
        tick(1);
        chk("t4_idle", DW'(status_state), DW'(0));
        cfg_length = 16'd9; arm = 1'b1;
        tick(2);
        chk("t4_armed", DW'(status_state), DW'(1));
        push_frame(10, 1);
        p0 = n_pop; fd0 = fd_count;
        pulse_sync();
        wait_pops(p0 + 5);
        arm = 1'b0;
        wait_pops(p0 + 10);
        tick(2);
        chk("t4_idle_after_drop", DW'(status_state), DW'(0));
        chk("t4_frame_done", DW'(fd_count - fd0), DW'(1));
        arm = 1'b1;
        tick(2);
        chk("t4_armed2", DW'(status_state), DW'(1));
        arm = 1'b0;
        tick(1);
        chk("t4_disarm_idle", DW'(status_state), DW'(0));
        chk("t4_disarm_no_valid", DW'(m_axis_valid), DW'(0));
        tick(5);

        // Auto cyclic with 3-high/2-low backpressure
        cfg_sync_mode = 2'd0; cfg_length = 16'd15;
        fd0 = fd_count;
        for (int f = 0; f < 16; f++) push_frame(16, 1);
        arm = 1'b1;
        for (int i = 0; i < 200; i++) begin
            m_axis_ready = ((i % 5) < 3);
            tick(1);
        end
        arm = 1'b0;
        for (int i = 0; i < 200 && status_state != 2'd0; i++) begin
            m_axis_ready = ((i % 5) < 3);
            tick(1);
        end
        m_axis_ready = 1'b1;
        chk("t3_idle", DW'(status_state), DW'(0));
        tick(2);
        rem = exp_q.size();
        chk("t3_whole_frames", DW'(rem % 16), DW'(0));
        chk("t3_frame_count", DW'(fd_count - fd0), DW'(16 - rem / 16));
        chk("t3_enough_frames", DW'((fd_count - fd0) >= 7), DW'(1));
        next_exp = next_exp - DW'(rem);
        exp_q.delete();

        // Reset at beat 3 of a frame
        cfg_sync_mode = 2'd1; cfg_oneshot = 1'b1; cfg_length = 16'd7; arm = 1'b1;
        tick(2);
        push_frame(3, 0);
        p0 = n_pop;
        pulse_sync();
        wait_pops(p0 + 3);
        reset = 1'b1; m_axis_ready = 1'b0; arm = 1'b0;
        tick(1);
        chk("t5_rst_valid", DW'(m_axis_valid), DW'(0));
        chk("t5_rst_sready", DW'(s_axis_ready), DW'(0));
        chk("t5_rst_last", DW'(m_axis_last), DW'(0));
        chk("t5_rst_state", DW'(status_state), DW'(0));
        chk("t5_rst_fd", DW'(frame_done), DW'(0));
        reset = 1'b0; m_axis_ready = 1'b1;
        tick(1);

        // Sync pulse in IDLE is discarded
        cfg_oneshot = 1'b0; cfg_length = 16'd1023;
        pulse_sync();
        tick(1);
        chk("t5_idle_pulse", DW'(status_state), DW'(0));
        arm = 1'b1;
        tick(3);
        chk("t5_stay_armed", DW'(status_state), DW'(1));
        chk("t5_ignored_zero", DW'(sync_ignored_cnt), DW'(0));
        tick(5);
        chk("t5_still_armed", DW'(status_state), DW'(1));

        // Saturation of the ignored-trigger counter
        push_frame(1024, 1);
        p0 = n_pop; fd0 = fd_count;
        pulse_sync();
        tick(1);
        chk("t6_run", DW'(status_state), DW'(2));
        for (int i = 0; i < 300; i++) begin
            pulse_sync();
            tick(1);
            if (i == 99) chk("t6_ignored_100", DW'(sync_ignored_cnt), DW'(100));
        end
        chk("t6_saturated", DW'(sync_ignored_cnt), DW'(255));
        wait_pops(p0 + 1024);
        tick(2);
        chk("t6_rearmed", DW'(status_state), DW'(1));
        chk("t6_frame_done", DW'(fd_count - fd0), DW'(1));
        arm = 1'b0;
        tick(2);
        chk("final_queue_empty", DW'(exp_q.size()), DW'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
